// File: rtl/nv_fifo_rws_16x256_pkg.sv
// rtl/nv_fifo_rws_16x256_pkg.sv - shared constants and FSM encoding for the 16x256 FIFO
package nv_fifo_rws_16x256_pkg;

  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_AW    = 4;
  localparam int FIFO_DW    = 256;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } fifo_state_e;

endpackage

// File: rtl/nv_ram_rws_16x256.sv
// rtl/nv_ram_rws_16x256.sv - 16x256 RAM, synchronous write, registered read address
module nv_ram_rws_16x256
  import nv_fifo_rws_16x256_pkg::*;
(
  input  logic               clk,
  input  logic [FIFO_AW-1:0] ra,
  input  logic               re,
  output logic [FIFO_DW-1:0] dout,
  input  logic [FIFO_AW-1:0] wa,
  input  logic               we,
  input  logic [FIFO_DW-1:0] di,
  input  logic [31:0]        pwrbus_ram_pd
);

  logic [FIFO_DW-1:0] mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] ra_q;
  logic               unused_pwrbus;

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= di;
    if (re) ra_q    <= ra;
  end

  // Output follows the stored address, so a write to mem[ra_q] is visible right after its edge.
  assign dout = mem[ra_q];

  assign unused_pwrbus = ^pwrbus_ram_pd;

endmodule

// File: rtl/nv_fifo_rws_16x256.sv
// rtl/nv_fifo_rws_16x256.sv - 16-entry 256-bit FIFO built around a registered-read-address RAM
module nv_fifo_rws_16x256
  import nv_fifo_rws_16x256_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  input  logic             flush,
  output logic [4:0]       count,
  output logic             err_ovf,
  output logic             err_unf,
  input  logic [31:0]      pwrbus_ram_pd
);

  localparam logic [4:0] FULL_CNT = 5'(DEPTH);

  fifo_state_e        state;
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW-1:0] rd_ptr_nxt;
  logic [4:0]         count_q;
  logic               err_ovf_q;
  logic               err_unf_q;
  logic               in_run;
  logic               full;
  logic               empty;
  logic               wr_acc;
  logic               rd_acc;
  logic               ram_re;
  logic [FIFO_AW-1:0] ram_ra;

  assign in_run  = (state == ST_RUN);
  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == 5'd0);
  assign wr_prdy = in_run & ~full;
  assign rd_pvld = in_run & ~empty;

  // Flush wins over both handshakes; neither pointer nor RAM sees a same-cycle transfer.
  assign wr_acc = wr_pvld & wr_prdy & ~flush;
  assign rd_acc = rd_pvld & rd_prdy & ~flush;

  always_comb begin
    rd_ptr_nxt = rd_ptr;
    if (flush)       rd_ptr_nxt = '0;
    else if (rd_acc) rd_ptr_nxt = rd_ptr + 1'b1;
  end

  // The RAM address register must track rd_ptr; INIT forces it to 0 after reset.
  assign ram_re = rd_acc | flush | ~in_run;
  assign ram_ra = in_run ? rd_ptr_nxt : '0;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state     <= ST_INIT;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      state <= ST_RUN;
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
        rd_ptr <= rd_ptr_nxt;
        case ({wr_acc, rd_acc})
          2'b10:   count_q <= count_q + 5'd1;
          2'b01:   count_q <= count_q - 5'd1;
          default: count_q <= count_q;
        endcase
        if (wr_pvld & ~wr_prdy & in_run & full) err_ovf_q <= 1'b1;
        if (rd_prdy & ~rd_pvld & in_run)        err_unf_q <= 1'b1;
      end
    end
  end

  assign count   = count_q;
  assign err_ovf = err_ovf_q;
  assign err_unf = err_unf_q;

  nv_ram_rws_16x256 u_ram (
    .clk           (clk),
    .ra            (ram_ra),
    .re            (ram_re),
    .dout          (rd_pd),
    .wa            (wr_ptr),
    .we            (wr_acc),
    .di            (wr_pd),
    .pwrbus_ram_pd (pwrbus_ram_pd)
  );

endmodule

// File: tb/tb_nv_fifo_rws_16x256.sv
// tb/tb_nv_fifo_rws_16x256.sv - directed table-driven bench for nv_fifo_rws_16x256
module tb_nv_fifo_rws_16x256;

  logic         clk = 1'b0;
  logic         reset_;
  logic         wr_pvld;
  logic         wr_prdy;
  logic [255:0] wr_pd;
  logic         rd_pvld;
  logic         rd_prdy;
  logic [255:0] rd_pd;
  logic         flush;
  logic [4:0]   count;
  logic         err_ovf;
  logic         err_unf;
  logic [31:0]  pwrbus_ram_pd;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       wp;
    logic       rp;
    logic       fl;
    logic [7:0] d;
    logic [4:0] cnt;
    logic       wrdy;
    logic       rvld;
    logic       chk_pd;
    logic [7:0] pd;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t vecs [7];

  nv_fifo_rws_16x256 dut (
    .clk           (clk),
    .reset_        (reset_),
    .wr_pvld       (wr_pvld),
    .wr_prdy       (wr_prdy),
    .wr_pd         (wr_pd),
    .rd_pvld       (rd_pvld),
    .rd_prdy       (rd_prdy),
    .rd_pd         (rd_pd),
    .flush         (flush),
    .count         (count),
    .err_ovf       (err_ovf),
    .err_unf       (err_unf),
    .pwrbus_ram_pd (pwrbus_ram_pd)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] pat(input logic [7:0] b);
    return {32{b}};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wp, input logic rp, input logic fl, input logic [7:0] d);
    wr_pvld = wp;
    rd_prdy = rp;
    flush   = fl;
    wr_pd   = pat(d);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 8'hA5, 5'd1, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 8'h11, 5'd1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 8'h22, 5'd1, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 8'h33, 5'd2, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd1, 1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

    reset_        = 1'b0;
    pwrbus_ram_pd = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    step();
    step();
    chk("rst_wr_prdy", 256'(wr_prdy), 256'(1'b0));
    chk("rst_rd_pvld", 256'(rd_pvld), 256'(1'b0));
    chk("rst_count",   256'(count),   256'(5'd0));
    chk("rst_errs",    256'({err_ovf, err_unf}), 256'(2'b00));

    reset_ = 1'b1;
    #1;
    chk("init_wr_prdy", 256'(wr_prdy), 256'(1'b0));
    chk("init_rd_pvld", 256'(rd_pvld), 256'(1'b0));
    step();
    chk("run_wr_prdy", 256'(wr_prdy), 256'(1'b1));
    chk("run_rd_pvld", 256'(rd_pvld), 256'(1'b0));
    chk("run_count",   256'(count),   256'(5'd0));

    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].wp, vecs[i].rp, vecs[i].fl, vecs[i].d);
      step();
      chk($sformatf("vec%0d_count", i),   256'(count),   256'(vecs[i].cnt));
      chk($sformatf("vec%0d_wr_prdy", i), 256'(wr_prdy), 256'(vecs[i].wrdy));
      chk($sformatf("vec%0d_rd_pvld", i), 256'(rd_pvld), 256'(vecs[i].rvld));
      chk($sformatf("vec%0d_errs", i),    256'({err_ovf, err_unf}), 256'({vecs[i].ovf, vecs[i].unf}));
      if (vecs[i].chk_pd) chk($sformatf("vec%0d_rd_pd", i), rd_pd, pat(vecs[i].pd));
    end

    // No bypass: empty FIFO with a write presented still shows rd_pvld=0 before the edge.
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    #1;
    chk("empty_no_bypass", 256'(rd_pvld), 256'(1'b0));

    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'(i));
      step();
    end
    chk("full_count",   256'(count),   256'(5'd16));
    chk("full_wr_prdy", 256'(wr_prdy), 256'(1'b0));
    chk("full_head",    rd_pd,         pat(8'h00));
    drive(1'b1, 1'b0, 1'b0, 8'hEE);
    step();
    chk("ovf_set",   256'(err_ovf), 256'(1'b1));
    chk("ovf_count", 256'(count),   256'(5'd16));

    // Full plus read: the read drains one entry, the write is refused.
    drive(1'b1, 1'b1, 1'b0, 8'hEE);
    #1;
    chk("full_rd_wr_prdy", 256'(wr_prdy), 256'(1'b0));
    step();
    chk("full_rd_count", 256'(count), 256'(5'd15));
    for (int i = 1; i < 16; i++) begin
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      #1;
      chk($sformatf("drain%0d_pd", i), rd_pd, pat(8'(i)));
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    #1;
    chk("drain_count",  256'(count),   256'(5'd0));
    chk("drain_pvld",   256'(rd_pvld), 256'(1'b0));
    chk("ovf_sticky",   256'(err_ovf), 256'(1'b1));

    drive(1'b1, 1'b0, 1'b0, 8'h00);
    step();
    for (int k = 1; k <= 40; k++) begin
      drive(1'b1, 1'b1, 1'b0, 8'(k));
      #1;
      chk($sformatf("stream%0d_pvld", k), 256'(rd_pvld), 256'(1'b1));
      chk($sformatf("stream%0d_pd", k),   rd_pd,         pat(8'(k - 1)));
      step();
      chk($sformatf("stream%0d_count", k), 256'(count), 256'(5'd1));
    end
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    #1;
    chk("stream_last_pd", rd_pd, pat(8'd40));
    step();
    chk("stream_end_count", 256'(count), 256'(5'd0));

    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'(8'h50 + i));
      step();
    end
    chk("pre_flush_count", 256'(count), 256'(5'd9));
    drive(1'b1, 1'b1, 1'b1, 8'h77);
    step();
    chk("flush_count", 256'(count),   256'(5'd0));
    chk("flush_pvld",  256'(rd_pvld), 256'(1'b0));
    chk("flush_errs",  256'({err_ovf, err_unf}), 256'(2'b10));
    drive(1'b1, 1'b0, 1'b0, 8'h88);
    step();
    chk("post_flush_count", 256'(count), 256'(5'd1));
    chk("post_flush_pd",    rd_pd,       pat(8'h88));
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    step();
    chk("post_flush_pop", 256'(count), 256'(5'd0));

    drive(1'b0, 1'b1, 1'b0, 8'h00);
    step();
    chk("unf_set",   256'(err_unf), 256'(1'b1));
    chk("unf_count", 256'(count),   256'(5'd0));
    drive(1'b1, 1'b0, 1'b0, 8'h99);
    step();
    chk("unf_ptrs_pd",    rd_pd,         pat(8'h99));
    chk("unf_ptrs_pvld",  256'(rd_pvld), 256'(1'b1));
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'(8'hA0 + i));
      step();
    end
    chk("pre_reset_count", 256'(count), 256'(5'd5));

    reset_ = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    #1;
    chk("midrst_count",   256'(count),   256'(5'd0));
    chk("midrst_errs",    256'({err_ovf, err_unf}), 256'(2'b00));
    chk("midrst_wr_prdy", 256'(wr_prdy), 256'(1'b0));
    chk("midrst_rd_pvld", 256'(rd_pvld), 256'(1'b0));
    step();
    reset_ = 1'b1;
    #1;
    chk("midrst_init_wr_prdy", 256'(wr_prdy), 256'(1'b0));
    step();
    chk("midrst_run_wr_prdy", 256'(wr_prdy), 256'(1'b1));
    drive(1'b1, 1'b0, 1'b0, 8'hC3);
    step();
    chk("midrst_wr_pd",    rd_pd,       pat(8'hC3));
    chk("midrst_wr_count", 256'(count), 256'(5'd1));
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nv_fifo_rws_16x256.md
NV_FIFO_RWS_16X256 -- requirements
Module: nv_fifo_rws_16x256

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entry count; only 16 is supported.
REQ-002 SHALL have parameter WIDTH, default 256, payload bits; only 256 is supported.
REQ-003 SHALL have port clk, input, 1: the single clock for all state.
REQ-004 SHALL have port reset_, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port wr_pvld, input, 1: write payload valid.
REQ-006 SHALL have port wr_prdy, output, 1: FIFO can accept a write.
REQ-007 SHALL have port wr_pd, input, 256: write payload.
REQ-008 SHALL have port rd_pvld, output, 1: head entry valid.
REQ-009 SHALL have port rd_prdy, input, 1: consumer accepts the head entry.
REQ-010 SHALL have port rd_pd, output, 256: head entry payload.
REQ-011 SHALL have port flush, input, 1: synchronous discard of all entries.
REQ-012 SHALL have port count, output, 5: current number of stored entries, 0..16.
REQ-013 SHALL have port err_ovf, output, 1: sticky flag, set when a write is presented while full.
REQ-014 SHALL have port err_unf, output, 1: sticky flag, set when rd_prdy is asserted while empty in RUN.
REQ-015 SHALL have port pwrbus_ram_pd, input, 32: passed unchanged to the RAM.

Function
REQ-016 SHALL implement a two-state FSM, INIT and RUN.
REQ-017 SHALL enter INIT on reset and go to RUN after exactly one clk edge.
REQ-018 In INIT, the FIFO SHALL drive wr_prdy=0, rd_pvld=0, RAM re=1 and ra=0, so that the RAM read-address register is defined.
REQ-019 A write SHALL be accepted only on wr_pvld & wr_prdy; it then writes wr_pd to RAM[wr_ptr] and increments wr_ptr modulo 16.
REQ-020 A read SHALL be accepted only on rd_pvld & rd_prdy; it then increments rd_ptr modulo 16.
REQ-021 The FIFO SHALL drive wr_prdy = (state==RUN) & (count!=16).
REQ-022 The FIFO SHALL drive rd_pvld = (state==RUN) & (count!=0).
REQ-023 SHALL drive the RAM read port with ra = next-cycle rd_ptr and re = read accept | flush | INIT, so that the RAM's registered read address always equals rd_ptr.
REQ-024 rd_pd SHALL be the RAM dout, i.e. RAM[rd_ptr], with no extra register.
REQ-025 Write-to-read latency SHALL be 1 cycle: data written at edge N appears on rd_pd with rd_pvld=1 after edge N, even when the FIFO was empty.
REQ-026 count SHALL update as +1 on write only, -1 on read only, and stay unchanged on a simultaneous write and read.
REQ-027 When full, wr_prdy SHALL be 0 even if a read happens in the same cycle; no write-through.
REQ-028 When empty, rd_pvld SHALL be 0; a same-cycle write SHALL NOT be bypassed to rd_pd.
REQ-029 Pointer wrap from 15 to 0 SHALL be seamless, with no bubble.
REQ-030 flush=1 SHALL clear wr_ptr, rd_ptr and count to 0 on that edge, override any same-cycle write or read (neither takes effect), and leave err_* unchanged.
REQ-031 err_ovf SHALL set on wr_pvld & ~wr_prdy in RUN with count==16, and clear only by reset.
REQ-032 err_unf SHALL set on rd_prdy & ~rd_pvld in RUN, and clear only by reset.

Reset
REQ-033 Asserting reset_ SHALL immediately force state=INIT, wr_ptr=0, rd_ptr=0, count=0, err_ovf=0, err_unf=0.
REQ-034 SHALL hold wr_prdy=0 and rd_pvld=0 while reset_ is low.
REQ-035 RAM contents SHALL NOT be reset; reset mid-operation discards all entries, and rd_pd is don't-care until the next write.

Structure
REQ-036 SHALL instantiate exactly one sub-module, nv_ram_rws_16x256 (clk, ra[3:0], re, dout[255:0], wa[3:0], we, di[255:0], pwrbus_ram_pd), with wa=wr_ptr, we=write accept, di=wr_pd.
REQ-037 The shared package SHALL hold the FSM state encoding (INIT=0, RUN=1) and the constants FIFO_DEPTH=16, FIFO_AW=4 and FIFO_DW=256.
REQ-038 All other logic (pointers, count, FSM, flags) SHALL be local; the implementation SHALL be about 150-250 lines of RTL.

Verification
REQ-039 Reset release: rd_pvld=0 and wr_prdy=0 for the first cycle, wr_prdy=1 in the second cycle, count=0.
REQ-040 Single write then read: write 256'hA5 at edge N -> rd_pvld=1 and rd_pd=256'hA5 after N; pop -> count=0 and rd_pvld=0.
REQ-041 Fill 16 values 0..15 with rd_prdy=0 -> count=16 and wr_prdy=0; keep wr_pvld=1 -> err_ovf=1; drain -> values 0..15 in order.
REQ-042 Continuous write and read for 40 cycles, incrementing data -> count stays at 1, in-order data across pointer wrap, no bubble.
REQ-043 flush at count=9 with a same-cycle write and read -> count=0, rd_pvld=0, next write is read back correctly.
REQ-044 rd_prdy=1 while empty -> err_unf=1, pointers unchanged; reset_ pulse mid-stream at count=5 -> count=0 and both err flags=0.
